// File: rtl/gpio_mul_pkg.sv
// Shared constants and types for the GPIO multiply accelerator:
// register offsets, status codes and FSM state encoding.
package gpio_mul_pkg;

  localparam logic [15:0] OFF_A1 = 16'h0000;
  localparam logic [15:0] OFF_A2 = 16'h0008;
  localparam logic [15:0] OFF_W  = 16'h0010;
  localparam logic [15:0] OFF_L  = 16'h0018;
  localparam logic [15:0] OFF_B  = 16'h0020;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_OVF  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CNT  = 2'd2
  } state_t;

  function automatic logic [15:0] reg_addr(input logic [15:0] base, input logic [15:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/gpio_mul_accel_if.sv
// Register bus between a host and the multiply accelerator.
interface gpio_mul_accel_if;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;

  modport master (output saddress, output srd, output swr, output sdata_in, input sdata_out);
  modport slave  (input saddress, input srd, input swr, input sdata_in, output sdata_out);
endinterface

// File: rtl/gpio_popcount.sv
// Purely combinational count of set bits in a W-bit vector.
module gpio_popcount #(
  parameter int W  = 48,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(din[i]);
    end
  end

endmodule

// File: rtl/gpio_mul_accel.sv
// Bus-mapped sequential shift-add multiplier with popcount, overflow
// status and a completion counter exposed on gpio_out.
module gpio_mul_accel
  import gpio_mul_pkg::*;
#(
  parameter int          OPW       = 24,
  parameter int          RESW      = 32,
  parameter logic [15:0] BASE_ADDR = 16'h01D8
) (
  input  logic             clk,
  input  logic             n_reset,
  gpio_mul_accel_if.slave  bus,
  input  logic [31:0]      gpio_in,
  input  logic             gpio_latch,
  output logic [31:0]      gpio_out,
  output logic [31:0]      gpio_in_s_insp
);

  localparam int PW = 2 * OPW;
  localparam int LW = $clog2(PW + 1);
  localparam int IW = $clog2(OPW);

  state_t          state_q, state_d;
  logic [OPW-1:0]  a1_q, a1_d, a2_q, a2_d;
  logic [RESW-1:0] w_q, w_d;
  logic [LW-1:0]   l_q, l_d;
  logic [1:0]      st_q, st_d;
  logic            rej_q, rej_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     insp_q, insp_d;
  logic            srd_hist_q, srd_hist_d;
  logic            swr_hist_q, swr_hist_d;
  logic            latch_hist_q, latch_hist_d;

  logic rd_rise, wr_rise, latch_rise;
  logic sel_a1, sel_a2, sel_w, sel_l, sel_b;
  logic busy, start, mul_step, finish, ovf;
  logic [LW-1:0] pop;
  logic unused_wdata;

  assign unused_wdata = ^bus.sdata_in;

  assign srd_hist_d   = bus.srd;
  assign swr_hist_d   = bus.swr;
  assign latch_hist_d = gpio_latch;
  assign rd_rise      = bus.srd & ~srd_hist_q;
  assign wr_rise      = bus.swr & ~swr_hist_q;
  assign latch_rise   = gpio_latch & ~latch_hist_q;

  assign sel_a1 = (bus.saddress == reg_addr(BASE_ADDR, OFF_A1));
  assign sel_a2 = (bus.saddress == reg_addr(BASE_ADDR, OFF_A2));
  assign sel_w  = (bus.saddress == reg_addr(BASE_ADDR, OFF_W));
  assign sel_l  = (bus.saddress == reg_addr(BASE_ADDR, OFF_L));
  assign sel_b  = (bus.saddress == reg_addr(BASE_ADDR, OFF_B));

  assign busy  = (state_q != S_IDLE);
  assign start = wr_rise & sel_a2 & ~busy;

  gpio_popcount #(.W(PW), .CW(LW)) u_popcount (
    .din   (prod_q),
    .count (pop)
  );

  assign ovf = |(prod_q >> RESW);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_MUL;
      S_MUL:   if (iter_q == IW'(OPW - 1)) state_d = S_CNT;
      S_CNT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mul_step = (state_q == S_MUL);
    finish   = (state_q == S_CNT);
  end

  // Reads sample the current flops, so a same-cycle write is seen only afterwards.
  always_comb begin
    a1_d    = a1_q;
    a2_d    = a2_q;
    w_d     = w_q;
    l_d     = l_q;
    st_d    = st_q;
    rej_d   = rej_q;
    prod_d  = prod_q;
    iter_d  = iter_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    insp_d  = insp_q;

    if (rd_rise) begin
      rdata_d = '0;
      if (sel_a1) rdata_d = 32'(a1_q);
      if (sel_a2) rdata_d = 32'(a2_q);
      if (sel_w)  rdata_d = 32'(w_q);
      if (sel_l)  rdata_d = 32'(l_q);
      if (sel_b)  rdata_d = {23'b0, rej_q, 6'b0, st_q};
    end

    if (wr_rise && (sel_a1 || sel_a2)) begin
      if (busy) begin
        rej_d = 1'b1;
      end else if (sel_a1) begin
        a1_d  = bus.sdata_in[OPW-1:0];
        w_d   = '0;
        l_d   = '0;
        st_d  = ST_OK;
        rej_d = 1'b0;
      end else begin
        a2_d   = bus.sdata_in[OPW-1:0];
        w_d    = '0;
        l_d    = '0;
        st_d   = ST_BUSY;
        prod_d = '0;
        iter_d = '0;
      end
    end

    if (mul_step) begin
      if (a2_q[iter_q]) prod_d = prod_q + (PW'(a1_q) << iter_q);
      iter_d = iter_q + IW'(1);
    end

    // Overflow keeps the most significant RESW bits of the product.
    if (finish) begin
      l_d   = pop;
      cnt_d = cnt_q + 16'd1;
      if (ovf) begin
        w_d  = prod_q[PW-1 -: RESW];
        st_d = ST_OVF;
      end else begin
        w_d  = prod_q[RESW-1:0];
        st_d = ST_OK;
      end
    end

    if (latch_rise) insp_d = gpio_in;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1_q         <= '0;
      a2_q         <= '0;
      w_q          <= '0;
      l_q          <= '0;
      st_q         <= ST_OK;
      rej_q        <= 1'b0;
      prod_q       <= '0;
      iter_q       <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      insp_q       <= '0;
      srd_hist_q   <= 1'b0;
      swr_hist_q   <= 1'b0;
      latch_hist_q <= 1'b0;
    end else begin
      a1_q         <= a1_d;
      a2_q         <= a2_d;
      w_q          <= w_d;
      l_q          <= l_d;
      st_q         <= st_d;
      rej_q        <= rej_d;
      prod_q       <= prod_d;
      iter_q       <= iter_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      insp_q       <= insp_d;
      srd_hist_q   <= srd_hist_d;
      swr_hist_q   <= swr_hist_d;
      latch_hist_q <= latch_hist_d;
    end
  end

  assign bus.sdata_out  = rdata_q;
  assign gpio_out       = {16'h0000, cnt_q};
  assign gpio_in_s_insp = insp_q;

endmodule

// File: tb/tb_gpio_mul_accel.sv
// Scoreboard bench for gpio_mul_accel: a transaction-level model predicts
// every register read; a monitor compares each read response as it appears.
module tb_gpio_mul_accel;
  import gpio_mul_pkg::*;

  localparam int          OPW    = 24;
  localparam int          RESW   = 32;
  localparam logic [15:0] BASE   = 16'h01D8;
  localparam logic [63:0] LIMIT  = (64'd1 << RESW) - 64'd1;
  localparam logic [31:0] OPMASK = 32'((64'd1 << OPW) - 64'd1);
  localparam logic [15:0] A_A1   = BASE + OFF_A1;
  localparam logic [15:0] A_A2   = BASE + OFF_A2;
  localparam logic [15:0] A_W    = BASE + OFF_W;
  localparam logic [15:0] A_L    = BASE + OFF_L;
  localparam logic [15:0] A_B    = BASE + OFF_B;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [31:0] gpio_in;
  logic        gpio_latch;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in_s_insp;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];

  // Reference model state, updated at transaction granularity.
  logic [31:0] m_a1, m_a2, m_w, m_l;
  logic [1:0]  m_st;
  bit          m_rej;
  logic [15:0] m_cnt;
  bit          m_pend;
  int          m_done;
  logic [63:0] m_prod;

  gpio_mul_accel_if bus();

  gpio_mul_accel #(.OPW(OPW), .RESW(RESW), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .bus            (bus),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    m_a1 = '0; m_a2 = '0; m_w = '0; m_l = '0; m_st = 2'd0;
    m_rej = 1'b0; m_cnt = '0; m_pend = 1'b0; m_done = 0; m_prod = '0;
  endfunction

  // Bring the model up to the state seen by clock edge e.
  function automatic void model_settle(input int e);
    if (m_pend && e > m_done) begin
      m_pend = 1'b0;
      m_l    = 32'($countones(m_prod));
      m_cnt  = m_cnt + 16'd1;
      if (m_prod > LIMIT) begin
        m_w  = 32'(m_prod >> (2 * OPW - RESW));
        m_st = 2'd2;
      end else begin
        m_w  = 32'(m_prod & LIMIT);
        m_st = 2'd0;
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] addr);
    if (addr == A_A1) return m_a1;
    if (addr == A_A2) return m_a2;
    if (addr == A_W)  return m_w;
    if (addr == A_L)  return m_l;
    if (addr == A_B)  return {23'b0, m_rej, 6'b0, m_st};
    return 32'h0;
  endfunction

  function automatic void model_write(input logic [15:0] addr, input logic [31:0] d, input int e);
    if (addr == A_A1 || addr == A_A2) begin
      if (m_pend) begin
        m_rej = 1'b1;
      end else if (addr == A_A1) begin
        m_a1 = d & OPMASK; m_w = '0; m_l = '0; m_st = 2'd0; m_rej = 1'b0;
      end else begin
        m_a2   = d & OPMASK; m_w = '0; m_l = '0; m_st = 2'd1;
        m_prod = 64'(m_a1) * 64'(m_a2);
        m_pend = 1'b1;
        m_done = e + OPW + 1;
      end
    end
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle; use_const selects a fixed expected read value over the model's.
  task automatic apply_stimulus(input bit do_rd, input bit do_wr, input logic [15:0] addr,
                                input logic [31:0] wdata, input string name,
                                input bit use_const, input logic [31:0] cval);
    int   e;
    exp_t x;
    @(negedge clk);
    e = cyc + 1;
    model_settle(e);
    if (do_rd) begin
      x.name = name;
      x.val  = use_const ? cval : model_read(addr);
      exp_q.push_back(x);
    end
    if (do_wr) model_write(addr, wdata, e);
    bus.saddress = addr;
    bus.sdata_in = wdata;
    bus.srd      = do_rd;
    bus.swr      = do_wr;
    @(negedge clk);
    bus.srd = 1'b0;
    bus.swr = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] d);
    apply_stimulus(1'b0, 1'b1, addr, d, "", 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [15:0] addr, input string name);
    apply_stimulus(1'b1, 1'b0, addr, 32'h0, name, 1'b0, 32'h0);
  endtask

  task automatic rd_const(input logic [15:0] addr, input string name, input logic [31:0] v);
    apply_stimulus(1'b1, 1'b0, addr, 32'h0, name, 1'b1, v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_all(input string tag);
    rd(A_A1, {tag, "_a1"});
    rd(A_A2, {tag, "_a2"});
    rd(A_W,  {tag, "_w"});
    rd(A_L,  {tag, "_l"});
    rd(A_B,  {tag, "_b"});
  endtask

  task automatic check_count(input string name);
    model_settle(cyc + 1);
    check_output(name, gpio_out, {16'h0000, m_cnt});
  endtask

  // Monitor: every rising read strobe yields sdata_out one edge later.
  initial begin
    bit   prev;
    bit   hit;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      hit  = bus.srd && !prev && n_reset;
      prev = n_reset ? bus.srd : 1'b0;
      if (hit) begin
        #1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL read_unexpected: got %h with no expected entry", bus.sdata_out);
        end else begin
          e = exp_q.pop_front();
          check_output(e.name, bus.sdata_out, e.val);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ra1, ra2, rd_data;
    bus.saddress = '0; bus.srd = 1'b0; bus.swr = 1'b0; bus.sdata_in = '0;
    gpio_in = '0; gpio_latch = 1'b0;
    model_reset();
    n_reset = 1'b0;
    idle(3);
    n_reset = 1'b1;

    $display("[TB] reset state");
    check_output("rst_gpio_out", gpio_out, 32'h0);
    check_output("rst_insp", gpio_in_s_insp, 32'h0);
    check_output("rst_sdata_out", bus.sdata_out, 32'h0);
    read_all("rst");

    $display("[TB] 3 x 5");
    wr(A_A1, 32'd3);
    wr(A_A2, 32'd5);
    idle(5);
    rd_const(A_B, "mul35_busy", 32'h1);
    idle(OPW);
    rd_const(A_W, "mul35_w", 32'd15);
    rd_const(A_L, "mul35_l", 32'd4);
    rd_const(A_B, "mul35_b", 32'h0);
    check_output("mul35_gpio_out", gpio_out, 32'd1);

    $display("[TB] overflow");
    wr(A_A1, 32'h00FF_FFFF);
    wr(A_A2, 32'h00FF_FFFF);
    idle(OPW + 3);
    rd_const(A_W, "ovf_w", 32'hFFFF_FE00);
    rd_const(A_L, "ovf_l", 32'd24);
    rd_const(A_B, "ovf_b", 32'h2);
    rd_const(A_A1, "ovf_a1_kept", 32'h00FF_FFFF);

    $display("[TB] writes while busy");
    wr(A_A1, 32'd7);
    wr(A_A2, 32'd9);
    idle(3);
    wr(A_A2, 32'h123);
    wr(A_A1, 32'h55);
    idle(OPW + 3);
    rd_const(A_A1, "busy_a1", 32'd7);
    rd_const(A_A2, "busy_a2", 32'd9);
    rd_const(A_W, "busy_w", 32'd63);
    rd_const(A_B, "busy_b", 32'h100);
    wr(A_A1, 32'h11);
    rd_const(A_B, "busy_clear_b", 32'h0);

    $display("[TB] read with write, unmapped");
    apply_stimulus(1'b1, 1'b1, A_A1, 32'hFF00_0022, "rw_old_a1", 1'b1, 32'h11);
    rd_const(A_A1, "rw_new_a1", 32'h22);
    rd_const(BASE + 16'h0028, "unmapped_28", 32'h0);
    rd_const(BASE + 16'h0004, "unmapped_04", 32'h0);
    rd_const(16'h0000, "unmapped_0", 32'h0);

    $display("[TB] gpio latch");
    @(negedge clk);
    gpio_in = 32'hA5A5_A5A5;
    gpio_latch = 1'b1;
    @(negedge clk);
    check_output("latch_capture", gpio_in_s_insp, 32'hA5A5_A5A5);
    gpio_in = 32'h1234_5678;
    idle(3);
    check_output("latch_held", gpio_in_s_insp, 32'hA5A5_A5A5);
    gpio_latch = 1'b0;
    idle(1);
    gpio_in = 32'h0F0F_0F0F;
    gpio_latch = 1'b1;
    idle(1);
    check_output("latch_second", gpio_in_s_insp, 32'h0F0F_0F0F);
    gpio_latch = 1'b0;

    $display("[TB] reset mid-operation");
    wr(A_A1, 32'd3);
    wr(A_A2, 32'd5);
    idle(6);
    n_reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
    check_output("midrst_gpio_out", gpio_out, 32'h0);
    check_output("midrst_insp", gpio_in_s_insp, 32'h0);
    check_output("midrst_sdata_out", bus.sdata_out, 32'h0);
    idle(OPW + 3);
    check_output("midrst_no_count", gpio_out, 32'h0);
    rd_const(A_A1, "midrst_a1", 32'h0);
    rd_const(A_A2, "midrst_a2", 32'h0);
    rd_const(A_W, "midrst_w", 32'h0);
    rd_const(A_B, "midrst_b", 32'h0);
    wr(A_A1, 32'd3);
    wr(A_A2, 32'd5);
    idle(OPW + 3);
    rd_const(A_W, "postrst_w", 32'd15);
    check_output("postrst_gpio_out", gpio_out, 32'd1);

    $display("[TB] randomized operations");
    for (int i = 0; i < 25; i++) begin
      ra1 = $urandom;
      ra2 = $urandom;
      if (i % 4 == 0) ra1 = OPMASK - ($urandom & 32'hFF);
      if (i % 5 == 0) ra2 = $urandom & 32'hFF;
      wr(A_A1, ra1);
      wr(A_A2, ra2);
      idle($urandom_range(0, OPW + 3));
      rd_data = $urandom;
      case ($urandom_range(0, 3))
        0:       rd(A_B, "rnd_poke_b");
        1:       rd(A_W, "rnd_poke_w");
        2:       wr(A_A1, rd_data);
        default: wr(A_A2, rd_data);
      endcase
      idle(OPW + 4);
      read_all("rnd");
      check_count("rnd_gpio_out");
    end

    idle(4);
    check_output("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpio_mul_accel.md
GPIO_MUL_ACCEL -- requirements
Module: gpio_mul_accel

Interface
REQ-001 The block SHALL have parameter OPW, default 24, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter RESW, default 32, giving the result width in bits; RESW <= 2*OPW.
REQ-003 The block SHALL have parameter BASE_ADDR, default 16'h01D8, giving the register base address; register stride is 8.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port n_reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port saddress, input, 16 bits: bus address.
REQ-007 Ports srd and swr, input, 1 bit each: read and write strobes, synchronous to clk.
REQ-008 Port sdata_in, input, 32 bits: write data.
REQ-009 Port sdata_out, output, 32 bits: registered read data.
REQ-010 Port gpio_in, input, 32 bits, and port gpio_latch, input, 1 bit: GPIO input and its capture strobe.
REQ-011 Port gpio_out, output, 32 bits: completion counter.
REQ-012 Port gpio_in_s_insp, output, 32 bits: latched gpio_in, for test inspection.

Function
REQ-013 The register map SHALL be: A1 at BASE+0x00 (RW), A2 at BASE+0x08 (RW), W at BASE+0x10 (RO), L at BASE+0x18 (RO), B at BASE+0x20 (RO).
REQ-014 Strobes SHALL act on the rising edge only: a clk edge with strobe=1 where the registered previous strobe value was 0.
REQ-015 A read SHALL load sdata_out with the addressed register at that clk edge; unmapped addresses load 0; sdata_out holds its value between reads.
REQ-016 A write to A1 or A2 SHALL load sdata_in[OPW-1:0]; the upper bits of the register read as 0.
REQ-017 A write to A1 SHALL clear W, L and B.
REQ-018 A write to A2 SHALL clear W and L and start an operation.
REQ-019 B encoding SHALL be: B[1:0] = 0 idle/ok, 1 busy, 2 overflow; B[8] = sticky write-rejected flag; all other bits 0.
REQ-020 The FSM SHALL have states IDLE, MUL and CNT, with transitions as follows:
  - IDLE -> MUL on an A2 write;
  - MUL -> CNT after exactly OPW iterations;
  - CNT -> IDLE after 1 cycle.
REQ-021 In MUL, each cycle SHALL perform one shift-add step over one bit of A2, LSB first, into a 2*OPW-bit product register, covering all OPW bits.
REQ-022 On the CNT edge the block SHALL perform all of the following:
  - set L to the popcount of the full 2*OPW-bit product;
  - if product > 2^RESW-1, set W = product[2*OPW-1 -: RESW] and B[1:0] = 2; otherwise set W = product[RESW-1:0] and B[1:0] = 0;
  - increment the completion counter.
REQ-023 Results SHALL be visible OPW+1 clk edges after the edge that captured the A2 write; B[1:0] reads 1 in between.
REQ-024 A1 and A2 SHALL retain their values after completion.
REQ-025 Writes to A1 or A2 while busy SHALL be ignored and SHALL set B[8]; B[8] is cleared by the next accepted A1 write.
REQ-026 A read and a write in the same cycle SHALL both be performed; the read returns the pre-write value.
REQ-027 gpio_out[15:0] SHALL be the completion counter, wrapping from 16'hFFFF to 0; gpio_out[31:16] SHALL be 0.
REQ-028 gpio_in SHALL be captured into gpio_in_s_insp on each gpio_latch rising edge, detected the same way as srd/swr.

Reset
REQ-029 n_reset low SHALL immediately clear all of the following, and the FSM SHALL enter IDLE:
  - sdata_out, gpio_out and gpio_in_s_insp;
  - A1, A2, W, L and B;
  - the product register and iteration counter;
  - the strobe-history flops.
REQ-030 A reset during MUL or CNT SHALL abort the operation with no completion count.

Structure
REQ-031 A shared package gpio_mul_pkg SHALL hold the following:
  - the register offset constants;
  - the B status codes;
  - the FSM state typedef.
REQ-032 The popcount SHALL be a sub-module gpio_popcount, parametrised by input width, purely combinational.

Verification
REQ-033 Write A1=3 then A2=5 -> B=1 for 24 cycles, then W=15, L=4, B=0, gpio_out=1.
REQ-034 Write A1=0xFFFFFF, A2=0xFFFFFF -> W=0xFFFFFE00, L=24, B=2.
REQ-035 Write A2 while busy -> operands unchanged, B[8]=1 after completion; a subsequent A1 write -> B=0.
REQ-036 Pulse n_reset low mid-MUL -> all registers 0, gpio_out unchanged from 0, a new operation completes normally.
REQ-037 Perform 65536 operations -> gpio_out wraps to 0; read of BASE+0x28 -> sdata_out=0.
REQ-038 Pulse gpio_latch with gpio_in=0xA5A5A5A5 -> gpio_in_s_insp=0xA5A5A5A5; holding gpio_latch high with a changing gpio_in -> no further capture.
